// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: arbiter state encodings, port indices and default bus widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Access counter width; covers ACC_CYC up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arb_if.sv
// Requester and RAM-side bundle of the RAM arbiter.
interface ram_arb_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // Handshake: a requester raises mX_req with we/addr/wdata stable and holds them
  // until mX_ack pulses for one cycle; mX_rdata is valid while mX_ack is high.
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              ram_cs;
  logic              ram_oe;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output ram_cs, ram_oe, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  ram_cs, ram_oe, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/ram_arb_rr_arb2.sv
// Two-requester round-robin picker: a lone requester wins, a tie goes to the port that was not last.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = PORT_CPU;
    case (req)
      2'b10:   gnt = PORT_LDR;
      2'b11:   gnt = ~last;
      default: gnt = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/ram_arb.sv
// Shares one RAM between the CPU sequencer (port 0) and the loader/debug port (port 1).
// Each access: grant in IDLE, ACC_CYC strobed cycles, then a one-cycle ack in RESP.
module ram_arb
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ACC_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  ram_arb_if.slave   bus,
  output arb_state_e dbg_state
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_CYC - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_oe_q, ram_oe_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;

  logic pick_gnt;
  logic pick_valid;

  rr_arb2 u_pick (
    .req   ({bus.m1_req, bus.m0_req}),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    ram_cs_d    = ram_cs_q;
    ram_oe_d    = ram_oe_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        ram_cs_d = 1'b0;
        ram_oe_d = 1'b0;
        ram_we_d = 1'b0;
        if (pick_valid) begin
          gnt_d       = pick_gnt;
          ram_addr_d  = (pick_gnt == PORT_LDR) ? bus.m1_addr  : bus.m0_addr;
          ram_wdata_d = (pick_gnt == PORT_LDR) ? bus.m1_wdata : bus.m0_wdata;
          ram_we_d    = (pick_gnt == PORT_LDR) ? bus.m1_we    : bus.m0_we;
          ram_oe_d    = ~ram_we_d;
          ram_cs_d    = 1'b1;
          cnt_d       = CNT_INIT;
          state_d     = ARB_ACCESS;
        end
      end

      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          // RAM data is only guaranteed in the final strobed cycle.
          if (ram_oe_q) begin
            if (gnt_q == PORT_LDR) m1_rdata_d = bus.ram_rdata;
            else                   m0_rdata_d = bus.ram_rdata;
          end
          ram_cs_d = 1'b0;
          ram_oe_d = 1'b0;
          ram_we_d = 1'b0;
          m0_ack_d = (gnt_q == PORT_CPU);
          m1_ack_d = (gnt_q == PORT_LDR);
          state_d  = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ARB_RESP: begin
        last_d  = gnt_q;
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      gnt_q       <= PORT_CPU;
      last_q      <= PORT_LDR;
      ram_cs_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      ram_cs_q    <= ram_cs_d;
      ram_oe_q    <= ram_oe_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
    end
  end

  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_oe    = ram_oe_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.m0_ack    = m0_ack_q;
  assign bus.m1_ack    = m1_ack_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: one instance with ACC_CYC=1 (a) and one with ACC_CYC=3 (b), each with a RAM model.
module tb_ram_arb;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_cnt = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- DUTs and RAM models ----------------
  ram_arb_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
  ram_arb_if #(.ADDR_W(32), .DATA_W(32)) ifb ();
  arb_state_e dbg_a, dbg_b;

  ram_arb #(.ADDR_W(32), .DATA_W(32), .ACC_CYC(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .dbg_state(dbg_a));
  ram_arb #(.ADDR_W(32), .DATA_W(32), .ACC_CYC(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .dbg_state(dbg_b));

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  int          oe_cyc_b = 0;

  assign ifa.ram_rdata = (ifa.ram_cs && ifa.ram_oe) ? mem_a[ifa.ram_addr[7:0]] : 32'h0;
  // RAM b only presents real data in the third strobed cycle; earlier cycles return junk.
  assign ifb.ram_rdata = !(ifb.ram_cs && ifb.ram_oe) ? 32'h0 :
                         (oe_cyc_b == 2) ? mem_b[ifb.ram_addr[7:0]] : (32'hBAD0_0000 | 32'(oe_cyc_b));

  always @(posedge clk) begin
    if (ifa.ram_cs && ifa.ram_we) mem_a[ifa.ram_addr[7:0]] = ifa.ram_wdata;
    if (ifb.ram_cs && ifb.ram_we) mem_b[ifb.ram_addr[7:0]] = ifb.ram_wdata;
  end
  always @(posedge clk) oe_cyc_b <= (ifb.ram_cs && ifb.ram_oe) ? oe_cyc_b + 1 : 0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_qa[$];
  logic [32:0] exp_qb[$];
  logic [32:0] exp_a, exp_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entries are {port, rdata}; acks are exclusive so queue order is also grant order.
  always @(negedge clk) begin
    if (ifa.m0_ack || ifa.m1_ack) begin
      check("ack_excl_a", 64'(ifa.m0_ack & ifa.m1_ack), 64'(0));
      if (exp_qa.size() == 0) check("spurious_ack_a", 64'(1), 64'(0));
      else begin
        exp_a = exp_qa.pop_front();
        check("rsp_a", 64'({ifa.m1_ack, ifa.m1_ack ? ifa.m1_rdata : ifa.m0_rdata}), 64'(exp_a));
      end
    end
    if (ifb.m0_ack || ifb.m1_ack) begin
      check("ack_excl_b", 64'(ifb.m0_ack & ifb.m1_ack), 64'(0));
      if (exp_qb.size() == 0) check("spurious_ack_b", 64'(1), 64'(0));
      else begin
        exp_b = exp_qb.pop_front();
        check("rsp_b", 64'({ifb.m1_ack, ifb.m1_ack ? ifb.m1_rdata : ifb.m0_rdata}), 64'(exp_b));
      end
    end
    if (ifa.ram_cs || ifa.ram_oe || ifa.ram_we)
      check("strobe_legal_a", 64'({ifa.ram_oe & ifa.ram_we, (ifa.ram_oe | ifa.ram_we) & ~ifa.ram_cs}), 64'(0));
    if (ifb.ram_cs || ifb.ram_oe || ifb.ram_we)
      check("strobe_legal_b", 64'({ifb.ram_oe & ifb.ram_we, (ifb.ram_oe | ifb.ram_we) & ~ifb.ram_cs}), 64'(0));
  end

  // ---------------- driver helpers ----------------
  int          res_lat, res_first_cs, res_cs_cyc, res_ack_cyc;
  logic        res_oe, res_we;
  logic [31:0] res_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input bit sel, input bit port);
    if (sel) return port ? ifb.m1_ack : ifb.m0_ack;
    return port ? ifa.m1_ack : ifa.m0_ack;
  endfunction

  function automatic logic [2:0] strobes_of(input bit sel);
    if (sel) return {ifb.ram_cs, ifb.ram_oe, ifb.ram_we};
    return {ifa.ram_cs, ifa.ram_oe, ifa.ram_we};
  endfunction

  task automatic drive(input bit sel, input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!sel && !port) begin ifa.m0_req = req; ifa.m0_we = we; ifa.m0_addr = addr; ifa.m0_wdata = wdata; end
    if (!sel &&  port) begin ifa.m1_req = req; ifa.m1_we = we; ifa.m1_addr = addr; ifa.m1_wdata = wdata; end
    if ( sel && !port) begin ifb.m0_req = req; ifb.m0_we = we; ifb.m0_addr = addr; ifb.m0_wdata = wdata; end
    if ( sel &&  port) begin ifb.m1_req = req; ifb.m1_we = we; ifb.m1_addr = addr; ifb.m1_wdata = wdata; end
  endtask

  task automatic wait_ack(input bit sel, input bit port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(sel, port) && n < 60);
    if (!ack_of(sel, port)) check("ack_timeout", 64'(0), 64'(1));
    res_ack_cyc = cyc_cnt;
  endtask

  // Issues one transaction at the start of a cycle and records strobe timing until its ack.
  task automatic xfer(input bit sel, input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input bit hold);
    logic [2:0] st;
    if (sel) exp_qb.push_back({port, exp_rd});
    else     exp_qa.push_back({port, exp_rd});
    drive(sel, port, 1'b1, we, addr, wdata);
    res_lat = 0; res_first_cs = 0; res_cs_cyc = 0;
    res_oe = 1'b0; res_we = 1'b0; res_addr = '0;
    do begin
      @(negedge clk);
      res_lat++;
      st = strobes_of(sel);
      if (st[2]) begin
        res_cs_cyc++;
        if (res_first_cs == 0) res_first_cs = res_lat;
        res_oe   = st[1];
        res_we   = st[0];
        res_addr = sel ? ifb.ram_addr : ifa.ram_addr;
      end
    end while (!ack_of(sel, port) && res_lat < 60);
    if (!ack_of(sel, port)) check("ack_timeout", 64'(0), 64'(1));
    res_ack_cyc = cyc_cnt;
    tick();
    if (!hold) drive(sel, port, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  int a0, n_acks, k;

  initial begin
    drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin mem_a[i] = 32'h0; mem_b[i] = 32'h0; end
    mem_a[8'h10] = 32'hDEAD_BEEF;
    mem_a[8'h30] = 32'hAAAA_0030;
    mem_a[8'h40] = 32'hBBBB_0040;
    mem_b[8'h50] = 32'hC0FF_EE03;
    mem_b[8'h60] = 32'h6060_6060;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state_a", 64'(dbg_a), 64'(ARB_IDLE));
    check("rst_outs_a", 64'({ifa.m0_ack, ifa.m1_ack, ifa.ram_cs, ifa.ram_oe, ifa.ram_we}), 64'(0));
    check("rst_data_a", 64'(ifa.ram_addr | ifa.ram_wdata | ifa.m0_rdata | ifa.m1_rdata), 64'(0));
    check("rst_state_b", 64'(dbg_b), 64'(ARB_IDLE));
    check("rst_outs_b", 64'({ifb.m0_ack, ifb.m1_ack, ifb.ram_cs, ifb.ram_oe, ifb.ram_we}), 64'(0));
    tick();

    // Single read on port 0, ACC_CYC=1: strobes in t+1, ack in t+2.
    xfer(0, 0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
    check("rd_latency", 64'(res_lat), 64'(3));
    check("rd_first_cs", 64'(res_first_cs), 64'(2));
    check("rd_cs_cycles", 64'(res_cs_cyc), 64'(1));
    check("rd_oe_we", 64'({res_oe, res_we}), 64'(2'b10));
    check("rd_addr", 64'(res_addr), 64'(32'h10));

    // Port 1 write then read, req held across the ack so acks land 3 cycles apart.
    xfer(0, 1, 1, 32'h20, 32'h1234_5678, 32'h0, 1);
    check("wr_oe_we", 64'({res_oe, res_we}), 64'(2'b01));
    check("wr_addr", 64'(res_addr), 64'(32'h20));
    a0 = res_ack_cyc;
    xfer(0, 1, 0, 32'h20, 32'h0, 32'h1234_5678, 0);
    check("wr_rd_gap", 64'(res_ack_cyc - a0), 64'(3));

    // Continuous contention: last grant was port 1, so order is 0,1,0,1,0,1.
    for (int i = 0; i < 3; i++) begin
      exp_qa.push_back({1'b0, 32'hAAAA_0030});
      exp_qa.push_back({1'b1, 32'hBBBB_0040});
    end
    drive(0, 0, 1, 0, 32'h30, 32'h0);
    drive(0, 1, 1, 0, 32'h40, 32'h0);
    n_acks = 0; k = 0;
    while (n_acks < 6 && k < 100) begin
      @(negedge clk);
      k++;
      if (ifa.m0_ack || ifa.m1_ack) n_acks++;
    end
    check("fair_acks", 64'(n_acks), 64'(6));
    tick();
    drive(0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0);

    // Late request: port 1 arrives during port 0's ACCESS and is served right after.
    exp_qa.push_back({1'b0, 32'hDEAD_BEEF});
    exp_qa.push_back({1'b1, 32'h1234_5678});
    drive(0, 0, 1, 0, 32'h10, 32'h0);
    tick();
    drive(0, 1, 1, 0, 32'h20, 32'h0);
    wait_ack(0, 0);
    a0 = res_ack_cyc;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    wait_ack(0, 1);
    check("late_gap", 64'(res_ack_cyc - a0), 64'(3));
    tick();
    drive(0, 1, 0, 0, 0, 0);

    // ACC_CYC=3 read: strobes t+1..t+3, ack t+4, data from the third strobe cycle.
    xfer(1, 0, 0, 32'h50, 32'h0, 32'hC0FF_EE03, 0);
    check("acc3_latency", 64'(res_lat), 64'(5));
    check("acc3_first_cs", 64'(res_first_cs), 64'(2));
    check("acc3_cs_cycles", 64'(res_cs_cyc), 64'(3));
    check("acc3_oe_we", 64'({res_oe, res_we}), 64'(2'b10));

    // Reset in the second ACCESS cycle; afterwards a tie must go to port 0.
    drive(1, 0, 1, 0, 32'h50, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 1, 1, 0, 32'h60, 32'h0);
    @(negedge clk);
    check("rstmid_strobes", 64'(strobes_of(1)), 64'(0));
    check("rstmid_acks", 64'({ifb.m0_ack, ifb.m1_ack}), 64'(0));
    check("rstmid_state", 64'(dbg_b), 64'(ARB_IDLE));
    exp_qb.push_back({1'b0, 32'hC0FF_EE03});
    exp_qb.push_back({1'b1, 32'h6060_6060});
    wait_ack(1, 0);
    a0 = res_ack_cyc;
    tick();
    drive(1, 0, 0, 0, 0, 0);
    wait_ack(1, 1);
    check("rstmid_gap", 64'(res_ack_cyc - a0), 64'(5));
    tick();
    drive(1, 1, 0, 0, 0, 0);

    repeat (4) tick();
    check("drain_a", 64'(exp_qa.size()), 64'(0));
    check("drain_b", 64'(exp_qb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
